alu_wide_sequencer: RTL
=======================

// Module: alu_wide_sequencer
// PURPOSE
//  Drives the 16-bit combinational ALU (op1/op2/sel/carry_in in; out/carry_out/zero/neg/overflow/parity
//  back) from a command handshake. Splits multi-word operands into WIDTH slices, low word first.
//  Optionally chains each slice's carry_out into the next slice's carry_in.
//  Returns the wide result and merged flags on a valid/ready result port.
// PARAMETERS
//  WIDTH  16  ALU word width; must match the ALU instance
//  WORDS  4   max words per operand (operand width = WIDTH*WORDS)
//  LENW   3   width of cmd_len; must hold WORDS ($clog2(WORDS+1))
// PORTS
//  clk            in   1            single clock, rising edge
//  rst            in   1            synchronous, active-high reset
//  cmd_valid      in   1            command present
//  cmd_ready      out  1            block can accept; high only in IDLE
//  cmd_sel        in   4            ALU operation code, passed unchanged to alu_sel
//  cmd_op1        in   WIDTH*WORDS  operand 1, word k = bits [k*WIDTH +: WIDTH]
//  cmd_op2        in   WIDTH*WORDS  operand 2
//  cmd_carry_in   in   1            carry into word 0 (and into every word when cmd_chain=0)
//  cmd_chain      in   1            1: word k>0 takes carry_out of word k-1
//  cmd_len        in   LENW         words to process, 1..WORDS
//  alu_op1        out  WIDTH        registered slice to ALU op1
//  alu_op2        out  WIDTH        registered slice to ALU op2
//  alu_sel        out  4            registered to ALU sel
//  alu_carry_in   out  1            registered to ALU carry_in
//  alu_out        in   WIDTH        ALU result
//  alu_carry_out, alu_zero, alu_neg, alu_overflow, alu_parity   in  1 each   ALU flags
//  res_valid      out  1            result present; held until res_ready
//  res_ready      in   1            consumer accepts
//  res_data       out  WIDTH*WORDS  result; words >= len are 0
//  res_carry      out  1            carry_out of last processed word
//  res_zero       out  1            AND of alu_zero over processed words
//  res_neg, res_overflow  out  1    flags of last processed word
//  res_parity     out  1            XOR of alu_parity over processed words
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1. All alu_*, res_* outputs are 0; word index and latched operands cleared.
//  - FSM IDLE -> EXEC on cmd_valid&cmd_ready. Latch op1/op2/sel/carry_in/chain/len; load word 0 onto alu_*.
//  - EXEC: each cycle capture alu_out into res_data word idx; fold flags; idx++.
//    If idx==len-1 -> DONE, else load word idx+1 onto alu_*.
//  - alu_carry_in for word k>0 = chain ? captured alu_carry_out(k-1) : latched carry_in.
//  - Latency: accept at edge 0; res_valid high after edge len+1 (len=1 -> 2 cycles).
//  - DONE: res_valid=1; all res_* stable while res_ready=0. On res_ready -> IDLE, clear res_valid.
//    cmd_ready rises the following cycle (no same-cycle bypass).
//  - cmd_len=0 is treated as 1. cmd_len>WORDS is clamped to WORDS.
//  - cmd_valid while not in IDLE is ignored (cmd_ready=0).
//  - res_data words above len are forced to 0 on accept.
//  - rst at any state, including mid-EXEC: abandon the command, return to reset values next edge, no result emitted.
//  - alu_* drive 0 in IDLE, so the ALU sees quiet inputs.
// STRUCTURE
//  - Shared package alu_pkg: ALU_WIDTH=16, SEL_W=4, FSM state typedef {IDLE,EXEC,DONE}.
//    Package also holds ALU sel code constants (SEL_ADD=4'd1, SEL_SUB=4'd2).
//  - Single module; one optional sub-module alu_flag_merge (zero AND, parity XOR, last-word neg/ovf/carry).
//  - Top-level test wrapper instantiates alu_wide_sequencer + the existing ALU back to back.
// TESTING (bench uses real ALU; sel 1 = add with carry_in, sel 2 = subtract)
//  1 len=1 sel=1 op1=125 op2=90 cin=1 -> res_data=0x00D8, zero=0, carry=0, res_valid 2 cycles after accept.
//  2 len=2 chain=1 sel=1 op1=0x0000FFFF op2=0x00000001 cin=0 -> res_data=0x00010000, carry=0, zero=0.
//  3 len=4 chain=1 sel=1 op1=64'hFFFF_FFFF_FFFF_FFFF op2=1 cin=0 -> res_data=0, zero=1, carry=1, 5-cycle latency.
//  4 len=2 sel=2 op1=op2=0x00190019 -> res_data=0, zero=1; len=0 command behaves as len=1.
//  5 hold res_ready=0 for 5 cycles in DONE -> res_* stable, cmd_ready=0; release -> next command accepted 1 cycle later.
//  6 assert rst during EXEC word 2 of a len=4 command -> next cycle res_valid=0, cmd_ready=1, alu_*=0.

Source files
------------

// File: rtl/alu_wide_sequencer_pkg.sv
// Shared types and constants for the wide ALU sequencer and its flag merger.
// Holds the 16-bit ALU word width, its select encoding and the sequencer FSM states.
package alu_wide_sequencer_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int SEL_W     = 4;

    localparam logic [SEL_W-1:0] SEL_ADD = 4'd1;
    localparam logic [SEL_W-1:0] SEL_SUB = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic overflow;
        logic parity;
    } alu_flags_t;

    // A zero-length command still runs one word; oversized lengths stop at the operand width.
    function automatic int clamp_len(input int len, input int words);
        if (len < 1) begin
            return 1;
        end
        if (len > words) begin
            return words;
        end
        return len;
    endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// Command and result handshake bundle between a requester and the wide ALU sequencer.
// The master drives commands and accepts results; the slave is the sequencer.
interface alu_wide_sequencer_if #(
    parameter int WIDTH = alu_wide_sequencer_pkg::ALU_WIDTH,
    parameter int WORDS = 4,
    parameter int LENW  = 3
);

    logic                                        cmd_valid;
    logic                                        cmd_ready;
    logic [alu_wide_sequencer_pkg::SEL_W-1:0]    cmd_sel;
    logic [WIDTH*WORDS-1:0]                      cmd_op1;
    logic [WIDTH*WORDS-1:0]                      cmd_op2;
    logic                                        cmd_carry_in;
    logic                                        cmd_chain;
    logic [LENW-1:0]                             cmd_len;

    logic                                        res_valid;
    logic                                        res_ready;
    logic [WIDTH*WORDS-1:0]                      res_data;
    logic                                        res_carry;
    logic                                        res_zero;
    logic                                        res_neg;
    logic                                        res_overflow;
    logic                                        res_parity;

    modport master (
        output cmd_valid, cmd_sel, cmd_op1, cmd_op2, cmd_carry_in, cmd_chain, cmd_len, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_neg, res_overflow, res_parity
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_op1, cmd_op2, cmd_carry_in, cmd_chain, cmd_len, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero, res_neg, res_overflow, res_parity
    );

endinterface

// File: rtl/alu_wide_sequencer_flag_merge.sv
// Folds the per-word ALU flags of one wide command into a single set of result flags.
// Zero is ANDed and parity XORed across words; carry, neg and overflow follow the last word folded.
module alu_wide_sequencer_flag_merge
    import alu_wide_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       fold,
    input  alu_flags_t flags,
    output alu_flags_t merged
);

    // Clear seeds zero=1 so the first folded word decides it outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            merged <= '0;
        end else if (clear) begin
            merged <= '{carry: 1'b0, zero: 1'b1, neg: 1'b0, overflow: 1'b0, parity: 1'b0};
        end else if (fold) begin
            merged.carry    <= flags.carry;
            merged.zero     <= merged.zero & flags.zero;
            merged.neg      <= flags.neg;
            merged.overflow <= flags.overflow;
            merged.parity   <= merged.parity ^ flags.parity;
        end
    end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Sequences a wide command through a 16-bit combinational ALU one word at a time, low word first,
// optionally chaining carries, and returns the assembled result with merged flags.
module alu_wide_sequencer
    import alu_wide_sequencer_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int WORDS = 4,
    parameter int LENW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    alu_wide_sequencer_if.slave bus,
    output logic [WIDTH-1:0]   alu_op1,
    output logic [WIDTH-1:0]   alu_op2,
    output logic [SEL_W-1:0]   alu_sel,
    output logic               alu_carry_in,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_carry_out,
    input  logic               alu_zero,
    input  logic               alu_neg,
    input  logic               alu_overflow,
    input  logic               alu_parity
);

    localparam int OPW = WIDTH * WORDS;

    state_t           state;
    state_t           next_state;

    logic [OPW-1:0]   op1_q;
    logic [OPW-1:0]   op2_q;
    logic             cin_q;
    logic             chain_q;
    logic [LENW-1:0]  len_q;

    logic             issuing;
    logic [LENW-1:0]  issue_idx;
    logic [LENW-1:0]  next_idx;
    logic [WIDTH-1:0] next_op1;
    logic [WIDTH-1:0] next_op2;

    logic             resp_valid;
    logic [LENW-1:0]  resp_idx;
    logic [WIDTH-1:0] resp_data;
    alu_flags_t       resp_flags;

    logic [OPW-1:0]   res_data_q;
    alu_flags_t       merged;

    logic             accept;
    logic             last_issue;
    logic             last_resp;

    assign accept     = (state == IDLE) && bus.cmd_valid;
    assign last_issue = issuing && (issue_idx == len_q - LENW'(1));
    assign last_resp  = resp_valid && (resp_idx == len_q - LENW'(1));
    assign next_idx   = issue_idx + LENW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE is reached only once the last word's response has been folded in.
    always_comb begin
        next_state    = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (last_resp) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        next_op1 = '0;
        next_op2 = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (next_idx == LENW'(k)) begin
                next_op1 = op1_q[k*WIDTH +: WIDTH];
                next_op2 = op2_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Issue side: word 0 goes out on accept, then one word per cycle; the ALU inputs drop to zero after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q        <= '0;
            op2_q        <= '0;
            cin_q        <= 1'b0;
            chain_q      <= 1'b0;
            len_q        <= '0;
            issuing      <= 1'b0;
            issue_idx    <= '0;
            alu_op1      <= '0;
            alu_op2      <= '0;
            alu_sel      <= '0;
            alu_carry_in <= 1'b0;
        end else if (accept) begin
            op1_q        <= bus.cmd_op1;
            op2_q        <= bus.cmd_op2;
            cin_q        <= bus.cmd_carry_in;
            chain_q      <= bus.cmd_chain;
            len_q        <= LENW'(clamp_len(int'(bus.cmd_len), WORDS));
            issuing      <= 1'b1;
            issue_idx    <= '0;
            alu_op1      <= bus.cmd_op1[WIDTH-1:0];
            alu_op2      <= bus.cmd_op2[WIDTH-1:0];
            alu_sel      <= bus.cmd_sel;
            alu_carry_in <= bus.cmd_carry_in;
        end else if (issuing) begin
            if (last_issue) begin
                issuing      <= 1'b0;
                alu_op1      <= '0;
                alu_op2      <= '0;
                alu_sel      <= '0;
                alu_carry_in <= 1'b0;
            end else begin
                issue_idx    <= next_idx;
                alu_op1      <= next_op1;
                alu_op2      <= next_op2;
                alu_carry_in <= chain_q ? alu_carry_out : cin_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
        end else begin
            resp_valid <= issuing;
            if (issuing) begin
                resp_idx   <= issue_idx;
                resp_data  <= alu_out;
                resp_flags <= '{carry: alu_carry_out, zero: alu_zero, neg: alu_neg,
                                overflow: alu_overflow, parity: alu_parity};
            end
        end
    end

    // Clearing on accept guarantees that words beyond the command length read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q <= '0;
        end else if (accept) begin
            res_data_q <= '0;
        end else if (resp_valid) begin
            for (int k = 0; k < WORDS; k++) begin
                if (resp_idx == LENW'(k)) begin
                    res_data_q[k*WIDTH +: WIDTH] <= resp_data;
                end
            end
        end
    end

    alu_wide_sequencer_flag_merge u_flag_merge (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .fold   (resp_valid),
        .flags  (resp_flags),
        .merged (merged)
    );

    assign bus.res_data     = res_data_q;
    assign bus.res_carry    = merged.carry;
    assign bus.res_zero     = merged.zero;
    assign bus.res_neg      = merged.neg;
    assign bus.res_overflow = merged.overflow;
    assign bus.res_parity   = merged.parity;

endmodule
